// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: states and transfer geometry shared by the SPI memory controller files
package spi_mem_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  localparam int ADDR_BITS = 8;
  localparam int DATA_BITS = 32;
  localparam int XFER_BITS = 40;
endpackage

// File: rtl/spi_mem_ctrl_if.sv
// spi_mem_ctrl_if: requester handshake plus SPI memory pins
interface spi_mem_ctrl_if
  import spi_mem_pkg::*;
#(
  parameter int AW = ADDR_BITS,
  parameter int DW = DATA_BITS
);
  logic req0, req1, ack0, ack1, busy, sclk, cs, mosi, miso;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] rdata;
  modport slave (
    input req0, addr0, req1, addr1, miso,
    output ack0, ack1, rdata, busy, sclk, cs, mosi
  );
  modport master (
    output req0, addr0, req1, addr1, miso,
    input ack0, ack1, rdata, busy, sclk, cs, mosi
  );
endinterface

// File: rtl/spi_rr_arb2.sv
// spi_rr_arb2: two-requester round-robin arbiter; on a tie the port other than rr_last wins
module spi_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic rr_last;
  always_comb gnt = (req == 2'b11) ? (rr_last ? 2'b01 : 2'b10) : req;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_last <= 1'b1;
    else if (en && |req) rr_last <= gnt[1];
endmodule

// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: SPI master reading a 256x32 SPI ROM on behalf of two round-robin requesters
module spi_mem_ctrl
  import spi_mem_pkg::*;
#(
  parameter int DIV = 4,
  parameter int AW = ADDR_BITS,
  parameter int DW = DATA_BITS
) (
  input logic           clk,
  input logic           rst_n,
  spi_mem_ctrl_if.slave bus
);
  localparam int CW = $clog2(DIV);
  localparam logic [5:0] K_ADDR = 6'(ADDR_BITS);
  localparam logic [5:0] K_LAST = 6'(XFER_BITS - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [5:0] bit_k, k_n;
  logic [AW-1:0] addr_q, addr_n;
  logic [DW-1:0] sh, sh_n, rdata, rdata_n;
  logic owner, own_n, sclk_q, sclk_n, cs_q, cs_n, mosi_q, mosi_n, last;
  logic [1:0] gnt, ack, ack_n;
  spi_rr_arb2 arb (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state == IDLE),
    .req  ({bus.req1, bus.req0}),
    .gnt  (gnt)
  );
  assign last = cnt == CW'(DIV - 1);
  // The address register doubles as the MOSI shifter; its zero fill drives MOSI low after bit 7
  always_comb begin
    state_n = state;
    cnt_n = last ? '0 : cnt + 1'b1;
    k_n = bit_k;
    addr_n = addr_q;
    sh_n = sh;
    own_n = owner;
    sclk_n = sclk_q;
    cs_n = cs_q;
    mosi_n = mosi_q;
    rdata_n = rdata;
    ack_n = 2'b00;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (|gnt) begin
          state_n = SETUP;
          addr_n = gnt[1] ? bus.addr1 : bus.addr0;
          own_n = gnt[1];
          cs_n = 1'b0;
          mosi_n = addr_n[AW-1];
        end
      end
      SETUP: if (last) begin
        state_n = SHIFT;
        sclk_n = 1'b1;
        k_n = '0;
      end
      SHIFT: if (last) begin
        if (sclk_q) begin
          sclk_n = 1'b0;
          sh_n = (bit_k >= K_ADDR) ? {sh[DW-2:0], bus.miso} : sh;
        end else if (bit_k == K_LAST) state_n = HOLD;
        else begin
          sclk_n = 1'b1;
          k_n = bit_k + 6'd1;
          mosi_n = addr_q[AW-2];
          addr_n = {addr_q[AW-2:0], 1'b0};
        end
      end
      HOLD: if (last) begin
        state_n = GAP;
        cs_n = 1'b1;
        rdata_n = sh;
        ack_n = owner ? 2'b10 : 2'b01;
      end
      GAP: state_n = last ? IDLE : GAP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bit_k <= '0;
      addr_q <= '0;
      sh <= '0;
      owner <= 1'b0;
      sclk_q <= 1'b0;
      cs_q <= 1'b1;
      mosi_q <= 1'b0;
      rdata <= '0;
      ack <= 2'b00;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_k <= k_n;
      addr_q <= addr_n;
      sh <= sh_n;
      owner <= own_n;
      sclk_q <= sclk_n;
      cs_q <= cs_n;
      mosi_q <= mosi_n;
      rdata <= rdata_n;
      ack <= ack_n;
    end
  assign bus.sclk = sclk_q;
  assign bus.cs = cs_q;
  assign bus.mosi = mosi_q;
  assign bus.rdata = rdata;
  assign bus.ack0 = ack[0];
  assign bus.ack1 = ack[1];
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_spi_mem_ctrl.sv
// tb_spi_mem_ctrl: randomized requesters, SPI ROM model and scoreboard for spi_mem_ctrl
module tb_spi_mem_ctrl;
  import spi_mem_pkg::*;
  localparam int DIV = 4;
  localparam int LAT = 82 * DIV + 1;
  localparam int HN = 16384;
  typedef struct packed {logic [7:0] a; logic [31:0] d;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int checks = 0, passes = 0, cyc = 0, idle_from = 0, viol = 0;
  logic [31:0] mem [256];
  logic [7:0] aq0[$], aq1[$];
  exp_t sb0[$], sb1[$];
  logic [1:0] hist [HN];
  logic [1:0] ack_s = 2'b00;
  spi_mem_ctrl_if bus ();
  spi_mem_ctrl #(.DIV(DIV)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", n, act, exp, cyc);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic issue(input int p, input logic [7:0] a);
    exp_t e;
    e.a = a;
    e.d = mem[a];
    if (p == 0) begin aq0.push_back(a); sb0.push_back(e); end
    else begin aq1.push_back(a); sb1.push_back(e); end
  endtask
  task automatic clear_q();
    aq0.delete(); aq1.delete(); sb0.delete(); sb1.delete();
  endtask
  task automatic drain();
    int n = 0;
    while ((aq0.size() + aq1.size() + sb0.size() + sb1.size()) != 0 && n < 5000) begin
      tick(1);
      n++;
    end
    chk("drain_pending", aq0.size() + aq1.size() + sb0.size() + sb1.size(), 0);
  endtask
  task automatic release_rst();
    rst_n = 1'b1;
    idle_from = cyc;
  endtask
  // SPI ROM: samples MOSI on SCLK fall, drives MISO shortly after SCLK rise; CS high resets it
  int mcnt = 0;
  logic sp = 1'b0;
  logic [7:0] maddr = '0, cap_addr = '0;
  initial begin
    bus.miso = 1'b0;
    forever begin
      @(bus.sclk, bus.cs);
      if (bus.cs) begin
        mcnt = 0;
        sp = 1'b0;
      end else if (bus.sclk != sp) begin
        sp = bus.sclk;
        if (!sp) begin
          if (mcnt < 8) maddr = {maddr[6:0], bus.mosi};
          mcnt++;
          if (mcnt == 8) cap_addr = maddr;
        end else if (mcnt >= 8 && mcnt < 40) begin
          #1 bus.miso = mem[maddr][39-mcnt];
        end
      end
    end
  end
  // Requesters hold REQ until ACK, then present the next queued address or drop REQ
  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.addr0 = '0; bus.addr1 = '0;
    forever begin
      @(posedge clk);
      #1;
      if (ack_s[0] && aq0.size() > 0) void'(aq0.pop_front());
      if (ack_s[1] && aq1.size() > 0) void'(aq1.pop_front());
      bus.req0 = rst_n && aq0.size() > 0;
      bus.req1 = rst_n && aq1.size() > 0;
      bus.addr0 = aq0.size() > 0 ? aq0[0] : 8'h00;
      bus.addr1 = aq1.size() > 0 ? aq1[0] : 8'h00;
    end
  end
  // Scoreboard: grant = first requesting cycle once idle, tie goes to the port not served last
  logic last_w = 1'b1;
  int g, w, p;
  exp_t e;
  always @(negedge clk) begin
    ack_s = {bus.ack1, bus.ack0};
    if (cyc < HN) hist[cyc] = {bus.req1, bus.req0};
    if (!rst_n) last_w = 1'b1;
    else if (bus.ack0 || bus.ack1) begin
      g = idle_from;
      while (g < cyc && hist[g] == 2'b00) g++;
      w = (hist[g] == 2'b11) ? (last_w ? 0 : 1) : (hist[g][1] ? 1 : 0);
      p = bus.ack1 ? 1 : 0;
      chk("ack_port", p, w);
      chk("ack_latency", cyc - g, LAT);
      chk("ack_single_port", {bus.ack1, bus.ack0} != 2'b11, 1);
      last_w = w[0];
      idle_from = cyc + DIV;
      if ((p == 0 ? sb0.size() : sb1.size()) == 0) chk("ack_unexpected", p, 2);
      else begin
        e = (p == 0) ? sb0.pop_front() : sb1.pop_front();
        chk("rdata", bus.rdata, e.d);
        chk("mosi_addr", cap_addr, e.a);
      end
    end
  end
  // Protocol monitor: SCLK phase lengths, 40 clocks per frame, CS gap, RDATA hold, BUSY
  int run = 0, rises = 0, hi_run = DIV;
  logic cs_p = 1'b1, sc_p = 1'b0;
  logic [31:0] rd_hold = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_hold = '0; cs_p = 1'b1; sc_p = 1'b0; hi_run = DIV;
    end else begin
      if (!bus.ack0 && !bus.ack1 && bus.rdata !== rd_hold) viol++;
      if (bus.ack0 || bus.ack1) rd_hold = bus.rdata;
      if (!bus.cs && !bus.busy) viol++;
      if (bus.cs && bus.sclk) viol++;
      if (!bus.cs) begin
        if (cs_p) begin
          if (hi_run < DIV || bus.sclk) viol++;
          run = 1; rises = 0;
        end else if (bus.sclk != sc_p) begin
          if (run != DIV) viol++;
          run = 1;
          if (bus.sclk) rises++;
        end else run++;
      end else begin
        if (!cs_p) begin
          if (run != 2 * DIV || rises != 40) viol++;
          hi_run = 1;
        end else hi_run++;
      end
      cs_p = bus.cs; sc_p = bus.sclk;
    end
  end
  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h3C] = 32'hDEADBEEF;
    mem[8'h00] = 32'h00000001;
    mem[8'hFF] = 32'h80000000;
    mem[8'hA5] = 32'h5A5AA5A5;
    tick(3);
    chk("rst_cs", bus.cs, 1);
    chk("rst_sclk", bus.sclk, 0);
    chk("rst_mosi", bus.mosi, 0);
    chk("rst_ack", {bus.ack1, bus.ack0}, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_busy", bus.busy, 0);
    release_rst();
    issue(0, 8'h3C);
    drain();
    #1 rst_n = 1'b0;
    tick(2);
    release_rst();
    issue(0, 8'h00);
    issue(1, 8'hFF);
    drain();
    for (int i = 0; i < 2; i++) begin
      issue(0, 8'($urandom));
      issue(1, 8'($urandom));
    end
    drain();
    issue(0, 8'hA5);
    issue(0, 8'($urandom));
    drain();
    issue(0, 8'($urandom));
    n = 0;
    while (bus.cs && n < 100) begin tick(1); n++; end
    chk("cs_fall", bus.cs, 0);
    tick(41 * DIV + 1);
    chk("sclk_high_k20", bus.sclk, 1);
    chk("falls_before_k20", mcnt, 20);
    #1 rst_n = 1'b0;
    clear_q();
    #1;
    chk("abort_cs", bus.cs, 1);
    chk("abort_sclk", bus.sclk, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_ack", {bus.ack1, bus.ack0}, 0);
    tick(3);
    release_rst();
    issue(1, 8'h55);
    drain();
    for (int i = 0; i < 8; i++) begin
      issue(int'($urandom_range(0, 1)), 8'($urandom));
      tick(int'($urandom_range(0, 300)));
    end
    drain();
    tick(2 * DIV);
    chk("protocol_violations", viol, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
